// File: rtl/data_memory.sv
// Handshaked byte-addressable data memory for the CPU load/store path.
// Supports RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW with configurable response latency.
`timescale 1ns/1ps
module data_memory #(
  parameter int unsigned WORDS   = 256,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        writeEnable,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  output logic        respValid,
  input  logic        respReady,
  output logic        respError,
  output logic [31:0] dataOut
);

  localparam int unsigned IDX_W    = $clog2(WORDS);
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? '0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             req_we_q, req_we_d;
  logic [2:0]       req_f3_q, req_f3_d;
  logic [IDX_W+1:0] req_addr_q, req_addr_d;
  logic             req_err_q, req_err_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_error_q, resp_error_d;
  logic [31:0]      data_out_q, data_out_d;

  logic [31:0] mem [WORDS];

  logic             accept;
  logic             in_legal, in_misaligned, in_err;
  logic             cur_we, cur_err;
  logic [2:0]       cur_f3;
  logic [IDX_W+1:0] cur_addr;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_val;
  logic             enter_resp;
  logic             wr_en;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^address[31:IDX_W+2];

  assign reqReady  = (state_q == S_IDLE) && resetN;
  assign respValid = resp_valid_q;
  assign respError = resp_error_q;
  assign dataOut   = data_out_q;

  always_comb begin
    accept = (state_q == S_IDLE) && reqValid && resetN;

    in_legal = 1'b0;
    if (writeEnable) begin
      in_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      in_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    in_misaligned = ((funct3[1:0] == 2'b01) && address[0]) ||
                    ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
    in_err = !in_legal || in_misaligned;

    // With LATENCY=0 the RESP entry edge is the acceptance edge, so decode from live inputs.
    if (state_q == S_IDLE) begin
      cur_we   = writeEnable;
      cur_f3   = funct3;
      cur_addr = address[IDX_W+1:0];
      cur_err  = in_err;
    end else begin
      cur_we   = req_we_q;
      cur_f3   = req_f3_q;
      cur_addr = req_addr_q;
      cur_err  = req_err_q;
    end
  end

  always_comb begin
    rd_word = mem[cur_addr[IDX_W+1:2]];
    rd_byte = 8'(rd_word >> {cur_addr[1:0], 3'b000});
    rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (cur_f3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_val = {24'h0, rd_byte};
      3'b101:  load_val = {16'h0, rd_half};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    wr_en = accept && writeEnable && !in_err;
    case (funct3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << address[1:0];
        wr_data = {4{dataIn[7:0]}};
      end
      2'b01: begin
        wr_be   = address[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{dataIn[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = dataIn;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[address[IDX_W+1:2]][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_we_d     = req_we_q;
    req_f3_d     = req_f3_q;
    req_addr_d   = req_addr_q;
    req_err_d    = req_err_q;
    resp_valid_d = resp_valid_q;
    resp_error_d = resp_error_q;
    data_out_d   = data_out_q;
    enter_resp   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_we_d   = writeEnable;
          req_f3_d   = funct3;
          req_addr_d = address[IDX_W+1:0];
          req_err_d  = in_err;
          if (LATENCY == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (respReady) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_resp) begin
      resp_valid_d = 1'b1;
      resp_error_d = cur_err;
      data_out_d   = (cur_err || cur_we) ? '0 : load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_we_q     <= 1'b0;
      req_f3_q     <= '0;
      req_addr_q   <= '0;
      req_err_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_we_q     <= req_we_d;
      req_f3_q     <= req_f3_d;
      req_addr_q   <= req_addr_d;
      req_err_q    <= req_err_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      data_out_q   <= data_out_d;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory (WORDS=256, LATENCY=1): vector table plus
// reset, backpressure and reset-during-store sequences.
`timescale 1ns/1ps
module tb_data_memory;

  logic        clk = 1'b0;
  logic        resetN;
  logic        reqValid;
  logic        reqReady;
  logic        writeEnable;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] dataIn;
  logic        respValid;
  logic        respReady;
  logic        respError;
  logic [31:0] dataOut;

  always #5 clk = ~clk;

  data_memory #(.WORDS(256), .LATENCY(1)) dut (
    .clk(clk), .resetN(resetN), .reqValid(reqValid), .reqReady(reqReady),
    .writeEnable(writeEnable), .funct3(funct3), .address(address), .dataIn(dataIn),
    .respValid(respValid), .respReady(respReady), .respError(respError), .dataOut(dataOut)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] din;
    logic        err;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] din, input logic err, input logic [31:0] data,
                     input string name);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.din = din;
    v.err = err; v.data = data; v.name = name;
    vecs.push_back(v);
  endtask

  // One full transaction with respReady held high; returns response and cycles to respValid.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] din, output logic err, output logic [31:0] data,
                     output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!reqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    reqValid = 1'b1; writeEnable = we; funct3 = f3; address = addr; dataIn = din;
    respReady = 1'b1;
    @(posedge clk);
    #1;
    reqValid = 1'b0; writeEnable = 1'b0; funct3 = 3'b000; address = '0; dataIn = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!respValid && lat < 20);
    err  = respError;
    data = dataOut;
  endtask

  initial begin
    logic        err;
    logic [31:0] data;
    int          lat;
    logic        seen_valid;

    resetN = 1'b0; reqValid = 1'b0; writeEnable = 1'b0; funct3 = '0;
    address = '0; dataIn = '0; respReady = 1'b1;

    repeat (2) begin
      @(negedge clk);
      check("rst_respValid", 32'(respValid), 32'd0);
      check("rst_dataOut", dataOut, 32'h0);
      check("rst_reqReady", 32'(reqReady), 32'd0);
    end
    resetN = 1'b1;
    @(negedge clk);
    check("post_rst_reqReady", 32'(reqReady), 32'd1);

    add(1'b1, 3'b010, 32'h10,  32'h8badf00d, 1'b0, 32'h0,        "sw_10");
    add(1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'h8badf00d, "lw_10");
    add(1'b1, 3'b000, 32'h13,  32'h000000A5, 1'b0, 32'h0,        "sb_13");
    add(1'b0, 3'b000, 32'h13,  32'h0,        1'b0, 32'hFFFFFFA5, "lb_13");
    add(1'b0, 3'b100, 32'h13,  32'h0,        1'b0, 32'h000000A5, "lbu_13");
    add(1'b0, 3'b001, 32'h12,  32'h0,        1'b0, 32'hFFFFA5AD, "lh_12");
    add(1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hA5ADF00D, "lw_10_after_sb");
    add(1'b1, 3'b010, 32'h20,  32'hCAFEF00D, 1'b0, 32'h0,        "sw_20");
    add(1'b1, 3'b010, 32'h22,  32'hFFFFFFFF, 1'b1, 32'h0,        "sw_22_misaligned");
    add(1'b0, 3'b001, 32'h11,  32'h0,        1'b1, 32'h0,        "lh_11_misaligned");
    add(1'b0, 3'b011, 32'h20,  32'h0,        1'b1, 32'h0,        "load_f3_011");
    add(1'b1, 3'b100, 32'h20,  32'h000000EE, 1'b1, 32'h0,        "store_f3_100");
    add(1'b0, 3'b010, 32'h20,  32'h0,        1'b0, 32'hCAFEF00D, "lw_20_unchanged");
    add(1'b1, 3'b001, 32'h22,  32'hFFFF1234, 1'b0, 32'h0,        "sh_22");
    add(1'b0, 3'b101, 32'h22,  32'h0,        1'b0, 32'h00001234, "lhu_22");
    add(1'b0, 3'b001, 32'h20,  32'h0,        1'b0, 32'hFFFFF00D, "lh_20");
    add(1'b0, 3'b010, 32'h20,  32'h0,        1'b0, 32'h1234F00D, "lw_20_after_sh");
    add(1'b0, 3'b000, 32'h21,  32'h0,        1'b0, 32'hFFFFFFF0, "lb_21");
    add(1'b0, 3'b100, 32'h20,  32'h0,        1'b0, 32'h0000000D, "lbu_20");
    add(1'b1, 3'b010, 32'h400, 32'h12345678, 1'b0, 32'h0,        "sw_400_wrap");
    add(1'b0, 3'b010, 32'h0,   32'h0,        1'b0, 32'h12345678, "lw_0_wrap");

    foreach (vecs[i]) begin
      txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].din, err, data, lat);
      check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].err));
      check({vecs[i].name, "_data"}, data, vecs[i].data);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'd2);
    end

    // Backpressure: response must hold while respReady is low.
    @(negedge clk);
    reqValid = 1'b1; writeEnable = 1'b0; funct3 = 3'b010; address = 32'h10; respReady = 1'b0;
    @(posedge clk);
    #1 reqValid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!respValid && lat < 20);
    for (int c = 0; c < 5; c++) begin
      check("bp_respValid", 32'(respValid), 32'd1);
      check("bp_dataOut", dataOut, 32'hA5ADF00D);
      check("bp_respError", 32'(respError), 32'd0);
      check("bp_reqReady", 32'(reqReady), 32'd0);
      @(negedge clk);
    end
    respReady = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_respValid", 32'(respValid), 32'd0);
    check("bp_release_reqReady", 32'(reqReady), 32'd1);

    // Reset while a store waits: write survives, response is dropped.
    @(negedge clk);
    reqValid = 1'b1; writeEnable = 1'b1; funct3 = 3'b010; address = 32'h30; dataIn = 32'hDEADBEEF;
    @(posedge clk);
    #1 reqValid = 1'b0; writeEnable = 1'b0;
    @(negedge clk);
    resetN = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen_valid |= respValid;
      if (c == 1) resetN = 1'b1;
    end
    check("rst_mid_no_resp", 32'(seen_valid), 32'd0);
    txn(1'b0, 3'b010, 32'h30, 32'h0, err, data, lat);
    check("rst_mid_lw_err", 32'(err), 32'd0);
    check("rst_mid_lw_data", data, 32'hDEADBEEF);
    check("rst_mid_lw_lat", 32'(lat), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
